// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//
// Shares one single-port, synchronous-read instruction RAM between the CPU fetch unit and a
// program loader / debug port. Byte addresses are converted to word indices, one access is
// granted per cycle, and read data is returned on the requester's response port one cycle
// after the grant. Fetch normally wins ties; after STARVE_LIMIT consecutive fetch grants
// while the loader waits, the loader wins the next tie.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   fetch_req/addr -> fetch_ready  fetch read request and same-cycle grant
//   fetch_rvalid/rdata/err         fetch response, one cycle after grant
//   ld_req/we/addr/wdata -> ld_ready  loader read/write request and same-cycle grant
//   ld_rvalid/rdata/err            loader response (write acks return rdata=0)
//   mem_en/we/addr/wdata, mem_rdata   RAM port; mem_rdata valid the cycle after mem_en
//
// Configuration:
//   IMEM_ARB_ALIGN_CHECK_EN  when defined, granted requests with addr[1:0]!=0 are
//                            acknowledged without touching memory and return err=1.
//                            When undefined, addr[1:0] are ignored and err is tied 0.

module imem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Fetch port
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_err,
  // Loader port
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_err,
  // Memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {StNorm, StBoost} state_e;

  state_e                state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;

  logic                  fetch_gnt, ld_gnt, gnt_any, misaligned;
  logic [DATA_WIDTH-1:0] gnt_addr;

  logic                  resp_valid_q, resp_sel_q, resp_we_q, resp_err_q;
  logic                  resp_data_ok;

  // Every address bit feeds either the index, the alignment check or nothing by design.
  logic                  unused_addr;
  assign unused_addr = ^{fetch_addr, ld_addr};

  // Grant: lone requester always wins; ties go to fetch in StNorm, loader in StBoost.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!rst) begin
      if (fetch_req && ld_req) begin
        if (state_q == StBoost) ld_gnt    = 1'b1;
        else                    fetch_gnt = 1'b1;
      end else begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req;
      end
    end
  end

  assign gnt_any  = fetch_gnt | ld_gnt;
  assign gnt_addr = ld_gnt ? ld_addr : fetch_addr;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign misaligned = gnt_any && (gnt_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Starvation counter and boost FSM.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = state_q;

    if (!ld_req || ld_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (fetch_gnt && (starve_cnt_q != 4'hF)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    case (state_q)
      StNorm:  if (starve_cnt_d >= StarveLimit) state_d = StBoost;
      StBoost: if (ld_gnt || !ld_req)           state_d = StNorm;
      default: state_d = StNorm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StNorm;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response tracking: which side was granted, and whether it carries data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_sel_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= gnt_any;
      resp_sel_q   <= ld_gnt;
      resp_we_q    <= ld_gnt & ld_we;
      resp_err_q   <= misaligned;
    end
  end

  // Memory side: idle port drives zeros; misaligned grants never reach the RAM.
  always_comb begin
    mem_en    = gnt_any & ~misaligned;
    mem_we    = mem_en & ld_gnt & ld_we;
    mem_addr  = mem_en ? gnt_addr[ADDR_WIDTH+1:2] : '0;
    mem_wdata = mem_we ? ld_wdata : '0;
  end

  assign fetch_ready  = fetch_gnt;
  assign ld_ready     = ld_gnt;

  assign resp_data_ok = resp_valid_q & ~resp_we_q & ~resp_err_q;

  assign fetch_rvalid = resp_valid_q & ~resp_sel_q;
  assign ld_rvalid    = resp_valid_q &  resp_sel_q;
  assign fetch_rdata  = (resp_data_ok & ~resp_sel_q) ? mem_rdata : '0;
  assign ld_rdata     = (resp_data_ok &  resp_sel_q) ? mem_rdata : '0;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign fetch_err = fetch_rvalid & resp_err_q;
  assign ld_err    = ld_rvalid & resp_err_q;
`else
  assign fetch_err = 1'b0;
  assign ld_err    = 1'b0;
`endif

endmodule
